// File: rtl/sdr_sample_framer.sv
// Write-side sample framer: packs I/Q samples into 32-bit words, prefixes each frame
// with a header word, and absorbs FIFO back-pressure in a 2-entry skid with drop accounting.
//   state | meaning
//   IDLE  | no frame open; waits for a held sample with enable high to load a header
//   PAY   | frame open; moves skid head into the output register until FRAME_LEN payloads
module sdr_sample_framer #(
   parameter int unsigned FRAME_LEN = 256,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             wr_clk,
   input  logic             wr_rst_n,
   input  logic             enable,
   input  logic             sample_valid,
   input  logic [15:0]      sample_i,
   input  logic [15:0]      sample_q,
   input  logic             clear_stats,
   output logic [31:0]      fifo_din,
   output logic             fifo_wr_en,
   input  logic             fifo_full,
   output logic [15:0]      frame_seq,
   output logic [CNT_W-1:0] drop_count,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic {ST_IDLE, ST_PAY} state_t;

   state_t             state_q, state_d;
   logic [31:0]        skid0_q, skid0_d, skid1_q, skid1_d;
   logic [1:0]         skid_cnt_q, skid_cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_data_q, out_data_d;
   logic [15:0]        pay_cnt_q, pay_cnt_d;
   logic [15:0]        frame_seq_q, frame_seq_d;
   logic [CNT_W-1:0]   drop_count_q, drop_count_d;
   logic               overflow_q, overflow_d;
   logic               lost_q, lost_d;

   logic               out_free;
   logic               skid_nonempty;
   logic               accept;
   logic               pop;
   logic               drop;
   logic               push;
   logic               hdr_load;
   logic               last_pay;
   logic [31:0]        in_word;

   assign in_word       = {sample_i, sample_q};
   assign fifo_wr_en    = out_valid_q & ~fifo_full;
   assign out_free      = ~out_valid_q | fifo_wr_en;
   assign skid_nonempty = (skid_cnt_q != 2'd0);
   assign accept        = sample_valid & ((state_q == ST_PAY) | enable);
   assign pop           = (state_q == ST_PAY) & skid_nonempty & out_free;
   assign drop          = accept & (skid_cnt_q == 2'd2) & ~pop;
   assign push          = accept & ~drop;
   assign hdr_load      = (state_q == ST_IDLE) & skid_nonempty & enable & out_free;
   assign last_pay      = (pay_cnt_q == 16'(FRAME_LEN - 1));

   // Sequencer and output register
   always_comb begin
      state_d     = state_q;
      pay_cnt_d   = pay_cnt_q;
      frame_seq_d = frame_seq_q;
      out_valid_d = out_valid_q & ~fifo_wr_en;
      out_data_d  = out_data_q;
      case (state_q)
         ST_IDLE: begin
            if (hdr_load) begin
               out_valid_d = 1'b1;
               out_data_d  = {SYNC_BYTE, 7'd0, lost_q | drop, frame_seq_q};
               frame_seq_d = frame_seq_q + 16'd1;
               state_d     = ST_PAY;
            end
         end
         ST_PAY: begin
            if (pop) begin
               out_valid_d = 1'b1;
               out_data_d  = skid0_q;
               if (last_pay) begin
                  pay_cnt_d = 16'd0;
                  state_d   = ST_IDLE;
               end else begin
                  pay_cnt_d = pay_cnt_q + 16'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Skid queue: pop shifts the tail forward, then a push lands in the first free slot
   always_comb begin
      skid0_d    = skid0_q;
      skid1_d    = skid1_q;
      skid_cnt_d = skid_cnt_q;
      if (pop) begin
         skid0_d    = skid1_q;
         skid_cnt_d = skid_cnt_q - 2'd1;
      end
      if (push) begin
         if (skid_cnt_d == 2'd0) begin
            skid0_d = in_word;
         end else begin
            skid1_d = in_word;
         end
         skid_cnt_d = skid_cnt_d + 2'd1;
      end
   end

   // Statistics: a drop coinciding with clear_stats leaves a count of one
   always_comb begin
      drop_count_d = drop_count_q;
      overflow_d   = overflow_q | drop;
      lost_d       = hdr_load ? 1'b0 : (lost_q | drop);
      if (clear_stats) begin
         drop_count_d = drop ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
         overflow_d   = drop;
      end else if (drop && !(&drop_count_q)) begin
         drop_count_d = drop_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state_q      <= ST_IDLE;
         skid0_q      <= '0;
         skid1_q      <= '0;
         skid_cnt_q   <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         pay_cnt_q    <= '0;
         frame_seq_q  <= '0;
         drop_count_q <= '0;
         overflow_q   <= 1'b0;
         lost_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         skid0_q      <= skid0_d;
         skid1_q      <= skid1_d;
         skid_cnt_q   <= skid_cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         pay_cnt_q    <= pay_cnt_d;
         frame_seq_q  <= frame_seq_d;
         drop_count_q <= drop_count_d;
         overflow_q   <= overflow_d;
         lost_q       <= lost_d;
      end
   end

   assign fifo_din   = out_data_q;
   assign frame_seq  = frame_seq_q;
   assign drop_count = drop_count_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q == ST_PAY) | skid_nonempty | out_valid_q;

endmodule

// File: tb/tb_sdr_sample_framer.sv
// Directed bench for sdr_sample_framer with FRAME_LEN=4: a per-cycle vector table for the
// first frame, then hand-written sequences for back-pressure, enable, seq wrap and reset.
module tb_sdr_sample_framer;

   logic        wr_clk = 1'b0;
   logic        wr_rst_n;
   logic        enable;
   logic        sample_valid;
   logic [15:0] sample_i, sample_q;
   logic        clear_stats;
   logic [31:0] fifo_din;
   logic        fifo_wr_en;
   logic        fifo_full;
   logic [15:0] frame_seq;
   logic [15:0] drop_count;
   logic        overflow;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   int full_viol = 0;
   logic [31:0] wq[$];
   logic [31:0] exp_q[$];

   sdr_sample_framer #(.FRAME_LEN(4), .SYNC_BYTE(8'hA5), .CNT_W(16)) dut (
      .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .enable(enable),
      .sample_valid(sample_valid), .sample_i(sample_i), .sample_q(sample_q),
      .clear_stats(clear_stats), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
      .fifo_full(fifo_full), .frame_seq(frame_seq), .drop_count(drop_count),
      .overflow(overflow), .busy(busy)
   );

   always #5 wr_clk = ~wr_clk;

   // Capture every FIFO write and flag any write issued while full
   always @(negedge wr_clk) begin
      if (fifo_wr_en) begin
         wq.push_back(fifo_din);
         if (fifo_full) full_viol++;
      end
   end

   typedef struct {
      logic        sv;
      logic [15:0] si;
      logic [15:0] sq;
      logic        ewr;
      logic [31:0] edin;
      logic [15:0] eseq;
      logic        ebusy;
   } vec_t;

   vec_t vt[10];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_q(string nm);
      chk({nm, " count"}, 32'(wq.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s[%0d]", nm, i), (i < wq.size()) ? wq[i] : 32'hDEAD_DEAD, exp_q[i]);
      wq.delete();
      exp_q.delete();
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge wr_clk);
         #1;
      end
   endtask

   task automatic send(logic [31:0] w);
      sample_valid = 1'b1;
      {sample_i, sample_q} = w;
      idle(1);
      sample_valid = 1'b0;
   endtask

   task automatic do_reset();
      wr_rst_n     = 1'b0;
      enable       = 1'b0;
      sample_valid = 1'b0;
      sample_i     = '0;
      sample_q     = '0;
      clear_stats  = 1'b0;
      fifo_full    = 1'b0;
      repeat (2) @(posedge wr_clk);
      @(negedge wr_clk);
      wr_rst_n = 1'b1;
      idle(1);
      wq.delete();
   endtask

   initial begin
      vt[0] = '{1'b1, 16'h1111, 16'hAAAA, 1'b0, 32'h0,         16'd0, 1'b0};
      vt[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0,         16'd0, 1'b1};
      vt[2] = '{1'b1, 16'h2222, 16'hBBBB, 1'b1, 32'hA500_0000, 16'd1, 1'b1};
      vt[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 32'h1111_AAAA, 16'd1, 1'b1};
      vt[4] = '{1'b1, 16'h3333, 16'hCCCC, 1'b1, 32'h2222_BBBB, 16'd1, 1'b1};
      vt[5] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0,         16'd1, 1'b1};
      vt[6] = '{1'b1, 16'h4444, 16'hDDDD, 1'b1, 32'h3333_CCCC, 16'd1, 1'b1};
      vt[7] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0,         16'd1, 1'b1};
      vt[8] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 32'h4444_DDDD, 16'd1, 1'b1};
      vt[9] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0,         16'd1, 1'b0};

      do_reset();
      chk("rst fifo_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("rst fifo_din", fifo_din, 32'd0);
      chk("rst frame_seq", 32'(frame_seq), 32'd0);
      chk("rst drop_count", 32'(drop_count), 32'd0);
      chk("rst overflow", 32'(overflow), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);

      // First frame, cycle by cycle
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sample_valid = vt[i].sv;
         sample_i     = vt[i].si;
         sample_q     = vt[i].sq;
         @(negedge wr_clk);
         chk($sformatf("vec%0d wr_en", i), 32'(fifo_wr_en), 32'(vt[i].ewr));
         if (vt[i].ewr) chk($sformatf("vec%0d din", i), fifo_din, vt[i].edin);
         chk($sformatf("vec%0d seq", i), 32'(frame_seq), 32'(vt[i].eseq));
         chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].ebusy));
         @(posedge wr_clk);
         #1;
      end
      wq.delete();

      // Three frames at half rate
      do_reset();
      enable = 1'b1;
      for (int f = 0; f < 3; f++) begin
         exp_q.push_back(32'hA500_0000 | 32'(f));
         for (int k = 0; k < 4; k++) begin
            send({16'(f), 16'(16'h0100 + k)});
            idle(1);
            exp_q.push_back({16'(f), 16'(16'h0100 + k)});
         end
      end
      idle(5);
      chk_q("three_frames");
      chk("three_frames seq", 32'(frame_seq), 32'd3);

      // Back-pressure: fifo_full for 10 cycles across a 5-sample burst
      do_reset();
      enable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         fifo_full    = 1'b1;
         sample_valid = (k < 5);
         {sample_i, sample_q} = 32'hB000_0000 | 32'(k);
         idle(1);
      end
      fifo_full    = 1'b0;
      sample_valid = 1'b0;
      idle(6);
      chk("bp drop_count", 32'(drop_count), 32'd3);
      chk("bp overflow", 32'(overflow), 32'd1);
      send(32'hB000_0005);
      idle(2);
      send(32'hB000_0006);
      idle(4);
      send(32'hB000_0007);
      idle(5);
      exp_q = '{32'hA500_0000, 32'hB000_0000, 32'hB000_0001, 32'hB000_0005,
                32'hB000_0006, 32'hA501_0001, 32'hB000_0007};
      chk_q("bp");

      clear_stats = 1'b1;
      idle(1);
      clear_stats = 1'b0;
      chk("clear drop_count", 32'(drop_count), 32'd0);
      chk("clear overflow", 32'(overflow), 32'd0);

      // Drop in the same cycle as clear_stats; lost survives the clear
      fifo_full = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sample_valid = 1'b1;
         clear_stats  = (k == 3);
         {sample_i, sample_q} = 32'hC000_0000 | 32'(k);
         idle(1);
      end
      sample_valid = 1'b0;
      clear_stats  = 1'b0;
      fifo_full    = 1'b0;
      @(negedge wr_clk);
      chk("clr+drop drop_count", 32'(drop_count), 32'd1);
      chk("clr+drop overflow", 32'(overflow), 32'd1);
      idle(6);
      send(32'hC000_0010);
      idle(5);
      exp_q = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hA501_0002, 32'hC000_0010};
      chk_q("clr+drop");
      chk("full_viol", 32'(full_viol), 32'd0);

      // Enable gating
      do_reset();
      for (int k = 0; k < 3; k++) send(32'hD000_0000 | 32'(k));
      idle(4);
      chk_q("en0");
      chk("en0 drop_count", 32'(drop_count), 32'd0);
      chk("en0 busy", 32'(busy), 32'd0);
      enable = 1'b1;
      send(32'hD000_0010);
      idle(3);
      enable = 1'b0;
      send(32'hD000_0011);
      idle(1);
      send(32'hD000_0012);
      idle(1);
      send(32'hD000_0013);
      idle(4);
      send(32'hD000_0014);
      idle(4);
      exp_q = '{32'hA500_0000, 32'hD000_0010, 32'hD000_0011, 32'hD000_0012, 32'hD000_0013};
      chk_q("en_drop");
      chk("en_drop busy", 32'(busy), 32'd0);

      // frame_seq wrap
      do_reset();
      force dut.frame_seq_q = 16'hFFFF;
      idle(1);
      release dut.frame_seq_q;
      idle(1);
      chk("wrap preload", 32'(frame_seq), 32'h0000_FFFF);
      enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         send(32'hE000_0000 | 32'(k));
         idle(1);
      end
      idle(4);
      send(32'hE000_0004);
      idle(5);
      exp_q = '{32'hA500_FFFF, 32'hE000_0000, 32'hE000_0001, 32'hE000_0002,
                32'hE000_0003, 32'hA500_0000, 32'hE000_0004};
      chk_q("wrap");
      chk("wrap seq", 32'(frame_seq), 32'd1);

      // Asynchronous reset mid-frame with two samples held
      do_reset();
      enable    = 1'b1;
      fifo_full = 1'b1;
      send(32'hF000_0000);
      send(32'hF000_0001);
      fifo_full = 1'b0;
      #1;
      chk("pre-rst wr_en", 32'(fifo_wr_en), 32'd1);
      chk("pre-rst busy", 32'(busy), 32'd1);
      wr_rst_n = 1'b0;
      #1;
      chk("async rst wr_en", 32'(fifo_wr_en), 32'd0);
      chk("async rst din", fifo_din, 32'd0);
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst seq", 32'(frame_seq), 32'd0);
      repeat (2) @(posedge wr_clk);
      @(negedge wr_clk);
      wr_rst_n = 1'b1;
      idle(2);
      chk_q("rst discard");
      send(32'hF000_0010);
      idle(5);
      exp_q = '{32'hA500_0000, 32'hF000_0010};
      chk_q("post-rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sdr_sample_framer.md
Name: sdr_sample_framer

Overview:
- Write-side producer for the cross-domain sample FIFO, living entirely in the wr_clk domain.
- Takes one complex baseband sample per sample_valid from the DDC.
- Packs each sample into a 32-bit word and inserts a header word before every frame of FRAME_LEN payload words.
- Writes into the FIFO write port under fifo_full back-pressure. Samples cannot be stalled, so overflow is absorbed by a 2-entry skid, then counted and flagged in-band.

Parameters:
- FRAME_LEN, 256, payload words per frame; legal range 2..65535.
- SYNC_BYTE, 8'hA5, header marker in bits [31:24].
- CNT_W, 16, width of drop_count.

Ports:
- wr_clk  in  1  write-domain clock.
- wr_rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  start new frames when high.
- sample_valid  in  1  sample strobe; no back-pressure upstream.
- sample_i  in  16  in-phase sample.
- sample_q  in  16  quadrature sample.
- clear_stats  in  1  synchronous clear of drop_count and overflow.
- fifo_din  out  32  word to FIFO.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag, wr_clk domain.
- frame_seq  out  16  sequence number the next header will carry.
- drop_count  out  CNT_W  dropped samples, saturating.
- overflow  out  1  sticky, set on any drop.
- busy  out  1  frame in progress or data held.

Behaviour:
- Reset values: fifo_din=0, fifo_wr_en=0, frame_seq=0, drop_count=0, overflow=0, busy=0. Skid is empty, output register is empty, payload count is 0, lost flag is 0. Reset mid-frame discards held data with no FIFO write.
- Payload word format: {sample_i, sample_q}.
- Header word format: {SYNC_BYTE, 7'd0, lost, frame_seq}.
  - lost=1 iff at least one sample was dropped since the previous header was loaded.
  - lost is cleared when the header is loaded.
- Skid stage: 2-entry sample queue, pushed on an accepted sample_valid.
- Output register (out_valid, out_data):
  - fifo_din=out_data.
  - fifo_wr_en = out_valid & ~fifo_full, combinational, so no write is ever issued while full.
  - The register is free when !out_valid or when it writes this cycle.
- Sequencer states:
  - IDLE: payload count=0, no frame open. Leave when the skid is non-empty and enable=1 (sampled now). Load the header, increment frame_seq (wraps 0xFFFF->0), go to PAY.
  - PAY: each cycle the output register is free and the skid is non-empty, pop the skid head into the output register and increment the payload count. After the FRAME_LEN-th payload load, return to IDLE. The next header is loaded in the following free cycle.
- Acceptance: sample_valid is accepted if a frame is open (PAY) or enable=1.
  - Samples arriving in IDLE with enable=0 are ignored; they are not drops.
  - A frame once opened always completes with FRAME_LEN payloads, regardless of enable.
- Drop: sample_valid accepted while the skid holds 2 entries and no pop occurs this cycle.
  - The sample is discarded.
  - drop_count increments, saturating at all-ones.
  - overflow is set.
  - lost is set.
  - Frame length is unaffected.
- Simultaneous push and pop on a full skid is legal, with no drop.
- clear_stats clears drop_count and overflow. If a drop occurs in the same cycle, the result is drop_count=1 and overflow=1. frame_seq and lost are not cleared.
- Latency: with an empty pipeline and fifo_full=0:
  - mid-frame sample in cycle 0 -> fifo_wr_en with that payload in cycle 2.
  - frame-opening sample in cycle 0 -> header in cycle 2, payload in cycle 3.
- Throughput: one word per cycle. Sustained input must not exceed FRAME_LEN/(FRAME_LEN+1) samples per clock; beyond that, drops are the specified behaviour.
- busy = (state==PAY) | skid non-empty | out_valid.

Test Plan:
- FRAME_LEN=4, enable=1, 4 samples at 1/2 rate, fifo_full=0 -> FIFO sees A5000000 then the 4 payloads in order; frame_seq becomes 1.
- 12 samples at 1/2 rate -> 3 frames with headers A5000000, A5000001, A5000002; each frame has exactly 4 payloads.
- fifo_full held high for 10 cycles during a burst of 5 consecutive samples:
  - no fifo_wr_en while full;
  - 3 drops, so drop_count=3 and overflow=1;
  - the next header has bit 16 set;
  - the frame still contains 4 payloads.
- enable=0 with samples present -> no writes, drop_count=0. Drop enable mid-frame -> the frame completes to 4 payloads, then no further header.
- frame_seq preloaded to 0xFFFF via 65535 frames, or forced -> header A500FFFF, then A5000000.
- Assert wr_rst_n low with 2 samples held and mid-frame -> all outputs return to reset values the same cycle; the first frame after reset carries seq 0.
